// File: rtl/nios2_mem_pkg.sv
// Shared types and helpers for the Nios II on-chip dual-port memory.
package nios2_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nios2_mem_rd_pipe.sv
// Read-return pipeline (1 or 2 stages) for one port; holds while stalled and
// keeps readdata at the last presented word when no strobe is issued.
module nios2_mem_rd_pipe
    import nios2_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    localparam int LAT = (READ_LATENCY > RD_LAT_MIN) ? RD_LAT_MAX : RD_LAT_MIN;

    logic              v1_r;
    logic [DATA_W-1:0] d1_r;
    logic              last_v_s;
    logic [DATA_W-1:0] last_d_s;
    logic [DATA_W-1:0] shown_r;
    logic              present_s;

    // First stage captures the array word on the accepting cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_r <= 1'b0;
            d1_r <= '0;
        end else if (!stall) begin
            v1_r <= in_valid;
            if (in_valid) begin
                d1_r <= in_data;
            end
        end
    end

    generate
        if (LAT == RD_LAT_MAX) begin : g_lat2
            logic              v2_r;
            logic [DATA_W-1:0] d2_r;

            // Optional output stage for the two-cycle latency build.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2_r <= 1'b0;
                    d2_r <= '0;
                end else if (!stall) begin
                    v2_r <= v1_r;
                    if (v1_r) begin
                        d2_r <= d1_r;
                    end
                end
            end

            assign last_v_s = v2_r;
            assign last_d_s = d2_r;
        end else begin : g_lat1
            assign last_v_s = v1_r;
            assign last_d_s = d1_r;
        end
    endgenerate

    // A pending word is only presented on an unstalled cycle.
    assign present_s = last_v_s & ~stall;

    // Remember the last presented word so readdata is stable between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown_r <= '0;
        end else if (present_s) begin
            shown_r <= last_d_s;
        end
    end

    assign readdata      = present_s ? last_d_s : shown_r;
    assign readdatavalid = present_s;

endmodule

// File: rtl/nios2_onchip_mem_dp.sv
// True-dual-port on-chip RAM with Avalon-MM slaves, byte enables and an
// optional zero-fill sequence after reset.
module nios2_onchip_mem_dp
    import nios2_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 10240,
    parameter int ADDR_W         = 14,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = "Nios2_RAM.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = AW1'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [DATA_W-1:0] mem_r [DEPTH];

    clr_state_e        state_r;
    clr_state_e        state_next_s;
    logic [IDX_W-1:0]  cnt_r;
    logic              init_done_s;
    logic              run_s;
    logic              stall_s;
    logic              clear_we_s;

    logic [ADDR_W-1:0] addr_s     [2];
    logic [NB-1:0]     be_s       [2];
    logic [DATA_W-1:0] wd_s       [2];
    logic              cs_s       [2];
    logic              rd_cmd_s   [2];
    logic              wr_cmd_s   [2];
    logic [IDX_W-1:0]  idx_s      [2];
    logic              in_range_s [2];
    logic              wr_s       [2];
    logic              rd_s       [2];
    logic [DATA_W-1:0] rword_s    [2];
    logic [DATA_W-1:0] rdata_s    [2];
    logic              rdv_s      [2];

    // Preloading from INIT_FILE belongs to the memory-initialisation flow.
    logic unused_init_file_s;
    assign unused_init_file_s = ^INIT_FILE;

    assign addr_s[0]   = s1_address;
    assign addr_s[1]   = s2_address;
    assign be_s[0]     = s1_byteenable;
    assign be_s[1]     = s2_byteenable;
    assign wd_s[0]     = s1_writedata;
    assign wd_s[1]     = s2_writedata;
    assign cs_s[0]     = s1_chipselect;
    assign cs_s[1]     = s2_chipselect;
    assign rd_cmd_s[0] = s1_read;
    assign rd_cmd_s[1] = s2_read;
    assign wr_cmd_s[0] = s1_write;
    assign wr_cmd_s[1] = s2_write;

    assign run_s      = clken & ~reset_req;
    assign stall_s    = ~init_done_s | ~run_s;
    assign clear_we_s = (state_r == ST_CLEAR) & run_s;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            assign idx_s[p]      = addr_s[p][IDX_W-1:0];
            assign in_range_s[p] = {1'b0, addr_s[p]} < DEPTH_L;
            // Read together with write counts as a write only.
            assign wr_s[p]       = cs_s[p] & wr_cmd_s[p] & ~stall_s & in_range_s[p];
            assign rd_s[p]       = cs_s[p] & rd_cmd_s[p] & ~wr_cmd_s[p] & ~stall_s;
            assign rword_s[p]    = in_range_s[p] ? mem_r[idx_s[p]] : '0;

            nios2_mem_rd_pipe #(
                .DATA_W       (DATA_W),
                .READ_LATENCY (READ_LATENCY)
            ) u_rd_pipe (
                .clk           (clk),
                .reset         (reset),
                .stall         (stall_s),
                .in_valid      (rd_s[p]),
                .in_data       (rword_s[p]),
                .readdata      (rdata_s[p]),
                .readdatavalid (rdv_s[p])
            );
        end
    endgenerate

    // Array update: zero-fill, then s2 lanes, then s1 lanes so s1 wins overlaps.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[cnt_r] <= '0;
        end
        for (int b = 0; b < NB; b++) begin
            if (wr_s[1] && be_s[1][b]) begin
                mem_r[idx_s[1]][b*8 +: 8] <= wd_s[1][b*8 +: 8];
            end
            if (wr_s[0] && be_s[0][b]) begin
                mem_r[idx_s[0]][b*8 +: 8] <= wd_s[0][b*8 +: 8];
            end
        end
    end

    // Zero-fill address counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear_we_s) begin
            cnt_r <= (cnt_r == LAST_IDX) ? '0 : cnt_r + IDX_W'(1);
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Clear FSM next state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clear_we_s && (cnt_r == LAST_IDX)) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = RESET_STATE;
        endcase
    end

    // Clear FSM output decode.
    always_comb begin
        init_done_s = 1'b0;
        if (state_r == ST_READY) begin
            init_done_s = 1'b1;
        end else begin
            init_done_s = 1'b0;
        end
    end

    assign init_done        = init_done_s;
    assign s1_waitrequest   = stall_s;
    assign s2_waitrequest   = stall_s;
    assign s1_readdata      = rdata_s[0];
    assign s2_readdata      = rdata_s[1];
    assign s1_readdatavalid = rdv_s[0];
    assign s2_readdatavalid = rdv_s[1];

endmodule

// File: tb/tb_nios2_onchip_mem_dp.sv
// Bench for nios2_onchip_mem_dp: latency-1 and latency-2 builds driven in
// parallel, checked every cycle against a word-level model plus literals.
module tb_nios2_onchip_mem_dp;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int AW  = 14;

    logic          clk;
    logic          reset;
    logic          clken;
    logic          reset_req;
    logic [1:0]    cs;
    logic [1:0]    rd;
    logic [1:0]    wr;
    logic [AW-1:0] addr [2];
    logic [3:0]    be   [2];
    logic [31:0]   wd   [2];

    logic [31:0]   rdat  [2][2];
    logic          rdv   [2][2];
    logic          wreq  [2][2];
    logic          idone [2];

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            nios2_onchip_mem_dp #(
                .DATA_W         (DW),
                .DEPTH          (DEP),
                .ADDR_W         (AW),
                .READ_LATENCY   (g + 1),
                .CLEAR_ON_RESET (1),
                .INIT_FILE      ("Nios2_RAM.hex")
            ) u_dut (
                .clk              (clk),
                .reset            (reset),
                .clken            (clken),
                .reset_req        (reset_req),
                .s1_address       (addr[0]),
                .s1_byteenable    (be[0]),
                .s1_chipselect    (cs[0]),
                .s1_read          (rd[0]),
                .s1_write         (wr[0]),
                .s1_writedata     (wd[0]),
                .s1_readdata      (rdat[g][0]),
                .s1_readdatavalid (rdv[g][0]),
                .s1_waitrequest   (wreq[g][0]),
                .s2_address       (addr[1]),
                .s2_byteenable    (be[1]),
                .s2_chipselect    (cs[1]),
                .s2_read          (rd[1]),
                .s2_write         (wr[1]),
                .s2_writedata     (wd[1]),
                .s2_readdata      (rdat[g][1]),
                .s2_readdatavalid (rdv[g][1]),
                .s2_waitrequest   (wreq[g][1]),
                .init_done        (idone[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Word-level model: memory image, zero-fill progress, and per-read
    // countdown of unstalled cycles until its strobe.
    logic [31:0] mm     [DEP];
    int          clr_cnt;
    bit          init_m;
    logic [31:0] last_m [4];
    logic [31:0] qd     [4][$];
    int          qn     [4][$];

    always @(negedge clk) begin : model_cmp
        bit          run;
        bit          exp_v;
        logic [31:0] v;
        int          k;
        if (reset) begin
            clr_cnt = 0;
            init_m  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                qd[i].delete();
                qn[i].delete();
                last_m[i] = 32'h0;
            end
        end
        run = clken && !reset_req;
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("waitrequest_l%0d_s%0d", g + 1, p + 1), 32'(wreq[g][p]),
                    32'(reset || !init_m || !run));
            end
            chk($sformatf("init_done_l%0d", g + 1), 32'(idone[g]), 32'(init_m));
        end
        for (int i = 0; i < 4; i++) begin
            exp_v = 1'b0;
            if (!reset && run && qn[i].size() > 0) begin
                for (int j = 0; j < qn[i].size(); j++) begin
                    qn[i][j] = qn[i][j] - 1;
                end
                if (qn[i][0] == 0) begin
                    exp_v     = 1'b1;
                    last_m[i] = qd[i].pop_front();
                    void'(qn[i].pop_front());
                end
            end
            chk($sformatf("readdatavalid_l%0d_s%0d", i / 2 + 1, i % 2 + 1),
                32'(rdv[i / 2][i % 2]), 32'(exp_v));
            chk($sformatf("readdata_l%0d_s%0d", i / 2 + 1, i % 2 + 1),
                rdat[i / 2][i % 2], last_m[i]);
        end
        if (!reset && run) begin
            if (!init_m) begin
                clr_cnt = clr_cnt + 1;
                if (clr_cnt == DEP) begin
                    init_m = 1'b1;
                    for (int i = 0; i < DEP; i++) mm[i] = 32'h0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (cs[p] && rd[p] && !wr[p]) begin
                        v = (addr[p] < 14'(DEP)) ? mm[addr[p][3:0]] : 32'h0;
                        for (int g = 0; g < 2; g++) begin
                            k = g * 2 + p;
                            qd[k].push_back(v);
                            qn[k].push_back(g + 1);
                        end
                    end
                end
                for (int p = 1; p >= 0; p--) begin
                    if (cs[p] && wr[p] && addr[p] < 14'(DEP)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[p][b]) mm[addr[p][3:0]][b*8 +: 8] = wd[p][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        cs = 2'b00;
        rd = 2'b00;
        wr = 2'b00;
    endtask

    task automatic set_cmd(input int p, input logic r, input logic w, input int a,
                           input logic [3:0] b, input logic [31:0] d);
        cs[p]   = 1'b1;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = 14'(a);
        be[p]   = b;
        wd[p]   = d;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!idone[0] && n < 200) begin
            n = n + 1;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd16);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string name, input int p, input logic [31:0] exp);
        chk({name, "_l1"}, rdat[0][p], exp);
        chk({name, "_l2"}, rdat[1][p], exp);
    endtask

    initial begin
        reset     = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        idle();
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0;
            be[p]   = '0;
            wd[p]   = '0;
        end
        step(3);
        reset = 1'b0;
        wait_init("init_cycles_first");

        // every address reads back zero after the fill
        for (int a = 0; a < DEP; a++) begin
            set_cmd(0, 1'b1, 1'b0, a, 4'h0, 32'h0);
            set_cmd(1, 1'b1, 1'b0, DEP - 1 - a, 4'h0, 32'h0);
            step(1);
        end
        idle();
        step(3);
        chk_pair("zero_fill_s1", 0, 32'h0000_0000);

        // partial byte-lane write over earlier contents
        set_cmd(0, 1'b0, 1'b1, 5, 4'hF, 32'h1122_3344);
        step(1);
        set_cmd(0, 1'b0, 1'b1, 5, 4'h3, 32'hDEAD_BEEF);
        step(1);
        set_cmd(0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("byteenable_merge", 0, 32'h1122_BEEF);

        // simultaneous writes: full overlap, then s1 owning only the low lanes
        set_cmd(0, 1'b0, 1'b1, 7, 4'hF, 32'hAAAA_AAAA);
        set_cmd(1, 1'b0, 1'b1, 7, 4'hF, 32'h5555_5555);
        step(1);
        set_cmd(0, 1'b0, 1'b1, 8, 4'h3, 32'hAAAA_AAAA);
        set_cmd(1, 1'b0, 1'b1, 8, 4'hF, 32'h5555_5555);
        step(1);
        set_cmd(0, 1'b1, 1'b0, 8, 4'h0, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 7, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("dual_write_s1_wins", 1, 32'hAAAA_AAAA);
        chk_pair("dual_write_lane_mix", 0, 32'h5555_AAAA);

        // mixed-port read during write sees the old word
        set_cmd(0, 1'b0, 1'b1, 3, 4'hF, 32'h1234_5678);
        set_cmd(1, 1'b1, 1'b0, 3, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("mixed_rdw_old", 1, 32'h0000_0000);
        set_cmd(1, 1'b1, 1'b0, 3, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("mixed_rdw_new", 1, 32'h1234_5678);

        // read and write together act as a write
        set_cmd(0, 1'b1, 1'b1, 9, 4'hF, 32'h0BAD_C0DE);
        step(1);
        set_cmd(0, 1'b1, 1'b0, 9, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("read_write_is_write", 0, 32'h0BAD_C0DE);

        // two reads in flight across a clken gap, with a command held off
        set_cmd(0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        step(1);
        set_cmd(0, 1'b1, 1'b0, 7, 4'h0, 32'h0);
        step(1);
        idle();
        clken = 1'b0;
        set_cmd(1, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        step(3);
        idle();
        clken = 1'b1;
        step(4);
        chk_pair("clken_gap_last", 0, 32'hAAAA_AAAA);
        set_cmd(1, 1'b1, 1'b0, 3, 4'h0, 32'h0);
        step(1);
        idle();
        reset_req = 1'b1;
        step(2);
        reset_req = 1'b0;
        step(3);

        // out-of-range addresses: writes dropped, reads return zero
        set_cmd(0, 1'b0, 1'b1, 4, 4'hF, 32'hCAFE_F00D);
        step(1);
        set_cmd(0, 1'b0, 1'b1, 20, 4'hF, 32'hFFFF_FFFF);
        set_cmd(1, 1'b0, 1'b1, 2040, 4'hF, 32'hFFFF_FFFF);
        step(1);
        set_cmd(0, 1'b1, 1'b0, 4, 4'h0, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 2040, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("oor_no_alias", 0, 32'hCAFE_F00D);
        chk_pair("oor_read_2040", 1, 32'h0000_0000);

        // reset with a read in flight, then again halfway through the fill
        set_cmd(0, 1'b1, 1'b0, 4, 4'h0, 32'h0);
        step(1);
        idle();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        step(5);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        wait_init("init_cycles_restart");
        set_cmd(0, 1'b1, 1'b0, 4, 4'h0, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 2040, 4'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk_pair("refill_addr4", 0, 32'h0000_0000);
        chk_pair("refill_read_2040", 1, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
